// File: rtl/piece_ctrl.sv
// piece_ctrl: owns the falling tetromino (type, rotation, grid position).
// Player commands and gravity become candidate moves. Each candidate is
// wall-checked locally, then queried against the settled stack through the
// board handshake. Locked pieces are offered to the board.
//
// Handshakes:
//   chk_req/chk_ack : chk_req is held high with cand_* stable until the
//                     cycle chk_ack is seen (chk_hit qualifies chk_ack).
//                     chk_ack may arrive in the same cycle chk_req rises.
//                     chk_req drops in the cycle after the ack.
//   lock_valid/lock_ready : lock_valid is held high with piece_* stable
//                     until the cycle lock_ready is seen. lock_valid drops
//                     in the cycle after that.
module piece_ctrl #(
    parameter int COLS       = 10,
    parameter int ROWS       = 20,
    parameter int SIZE       = 16,
    parameter int ORIGIN_X   = 160,
    parameter int ORIGIN_Y   = 80,
    parameter int FALL_TICKS = 25000000,
    parameter int SPAWN_COL  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  next_piece,
    output logic        next_take,
    input  logic        cmd_left,
    input  logic        cmd_right,
    input  logic        cmd_rot,
    input  logic        cmd_drop,
    output logic        chk_req,
    output logic [5:0]  cand_col,
    output logic [5:0]  cand_row,
    output logic [11:0] cand_mask,
    input  logic        chk_ack,
    input  logic        chk_hit,
    output logic        lock_valid,
    input  logic        lock_ready,
    output logic [5:0]  piece_col,
    output logic [5:0]  piece_row,
    output logic [11:0] piece_mask,
    output logic [9:0]  ref_x,
    output logic [9:0]  ref_y,
    output logic        game_over,
    output logic [2:0]  dbg_state
);

    localparam int CNT_W = (FALL_TICKS > 1) ? $clog2(FALL_TICKS) : 1;

    typedef enum logic [2:0] {
        S_SPAWN = 3'd0,
        S_IDLE  = 3'd1,
        S_CHECK = 3'd2,
        S_WAIT  = 3'd3,
        S_LOCK  = 3'd4,
        S_OVER  = 3'd5
    } state_t;

    // What a rejected candidate means depends on the kind of move.
    typedef enum logic [1:0] {
        K_SPAWN = 2'd0,
        K_SIDE  = 2'd1,
        K_DOWN  = 2'd2
    } kind_t;

    // Shape ROM: type 0..6 = I O T S Z J L, rotation clockwise.
    function automatic logic [11:0] shape_mask(input logic [2:0] t, input logic [1:0] r);
        logic [11:0] m;
        m = 12'h00F;
        case (t)
            3'd1: m = 12'h0C6;
            3'd2: case (r)
                2'd0: m = 12'h0E2;
                2'd1: m = 12'h2C2;
                2'd2: m = 12'h2E0;
                default: m = 12'h262;
            endcase
            3'd3: case (r)
                2'd0: m = 12'h066;
                2'd1: m = 12'h4C2;
                2'd2: m = 12'h3C0;
                default: m = 12'h261;
            endcase
            3'd4: case (r)
                2'd0: m = 12'h0C3;
                2'd1: m = 12'h2C4;
                2'd2: m = 12'h660;
                default: m = 12'h162;
            endcase
            3'd5: case (r)
                2'd0: m = 12'h0E1;
                2'd1: m = 12'h246;
                2'd2: m = 12'h4E0;
                default: m = 12'h342;
            endcase
            3'd6: case (r)
                2'd0: m = 12'h0E4;
                2'd1: m = 12'h642;
                2'd2: m = 12'h1E0;
                default: m = 12'h243;
            endcase
            default: m = r[0] ? 12'hA42 : 12'h00F;
        endcase
        return m;
    endfunction

    // Column offset of a mask bit, 7-bit two's complement.
    function automatic logic [6:0] cell_dx(input int i);
        logic [6:0] d;
        case (i)
            0, 5, 8:  d = 7'h7F;
            2, 7, 10: d = 7'd1;
            3:        d = 7'd2;
            4:        d = 7'd3;
            default:  d = 7'd0;
        endcase
        return d;
    endfunction

    // Row offset of a mask bit.
    function automatic logic [6:0] cell_dy(input int i);
        logic [6:0] d;
        if (i <= 4)       d = 7'd0;
        else if (i <= 7)  d = 7'd1;
        else if (i <= 10) d = 7'd2;
        else              d = 7'd3;
        return d;
    endfunction

    state_t      state_q, state_d;
    kind_t       kind_q, kind_d;
    logic [2:0]  piece_type_q, piece_type_d;
    logic [1:0]  piece_rot_q, piece_rot_d;
    logic [5:0]  piece_col_q, piece_col_d;
    logic [5:0]  piece_row_q, piece_row_d;
    logic [11:0] piece_mask_q, piece_mask_d;
    logic [1:0]  cand_rot_q, cand_rot_d;
    logic [5:0]  cand_col_q, cand_col_d;
    logic [5:0]  cand_row_q, cand_row_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        fall_pend_q, fall_pend_d;
    logic        chk_req_q, chk_req_d;
    logic        lock_valid_q, lock_valid_d;
    logic        next_take_q, next_take_d;
    logic        game_over_q, game_over_d;
    logic [9:0]  ref_x_q, ref_x_d;
    logic [9:0]  ref_y_q, ref_y_d;

    logic        oob;
    logic [6:0]  cx, cy;
    logic        commit;
    logic        down_go;
    state_t      hit_state;

    assign cand_mask  = shape_mask(piece_type_q, cand_rot_q);
    assign cand_col   = cand_col_q;
    assign cand_row   = cand_row_q;
    assign chk_req    = chk_req_q;
    assign lock_valid = lock_valid_q;
    assign next_take  = next_take_q;
    assign game_over  = game_over_q;
    assign piece_col  = piece_col_q;
    assign piece_row  = piece_row_q;
    assign piece_mask = piece_mask_q;
    assign ref_x      = ref_x_q;
    assign ref_y      = ref_y_q;
    assign dbg_state  = state_q;

    // Wall test: every occupied cell of the candidate must lie inside the field.
    always_comb begin
        oob = 1'b0;
        cx  = 7'd0;
        cy  = 7'd0;
        for (int i = 0; i < 12; i++) begin
            cx = {cand_col_q[5], cand_col_q} + cell_dx(i);
            cy = {cand_row_q[5], cand_row_q} + cell_dy(i);
            if (cand_mask[i] && (cx[6] || (cx >= 7'(COLS)) || cy[6] || (cy >= 7'(ROWS))))
                oob = 1'b1;
        end
    end

    // Next-state, candidate construction, commit, gravity and registered outputs.
    always_comb begin
        state_d      = state_q;
        kind_d       = kind_q;
        piece_type_d = piece_type_q;
        piece_rot_d  = piece_rot_q;
        piece_col_d  = piece_col_q;
        piece_row_d  = piece_row_q;
        piece_mask_d = piece_mask_q;
        cand_rot_d   = cand_rot_q;
        cand_col_d   = cand_col_q;
        cand_row_d   = cand_row_q;
        cnt_d        = cnt_q;
        fall_pend_d  = fall_pend_q;
        next_take_d  = 1'b0;
        commit       = 1'b0;
        down_go      = 1'b0;

        // A rejected candidate ends the game, locks the piece, or is dropped.
        case (kind_q)
            K_SPAWN: hit_state = S_OVER;
            K_DOWN:  hit_state = S_LOCK;
            default: hit_state = S_IDLE;
        endcase

        case (state_q)
            S_SPAWN: begin
                piece_type_d = (next_piece == 3'd7) ? 3'd0 : next_piece;
                next_take_d  = 1'b1;
                cand_rot_d   = 2'd0;
                cand_col_d   = 6'(SPAWN_COL);
                cand_row_d   = 6'd0;
                kind_d       = K_SPAWN;
                state_d      = S_CHECK;
            end
            S_IDLE: begin
                cand_rot_d = piece_rot_q;
                cand_col_d = piece_col_q;
                cand_row_d = piece_row_q;
                kind_d     = K_SIDE;
                if (cmd_rot) begin
                    cand_rot_d = piece_rot_q + 2'd1;
                    state_d    = S_CHECK;
                end else if (cmd_left) begin
                    cand_col_d = piece_col_q - 6'd1;
                    state_d    = S_CHECK;
                end else if (cmd_right) begin
                    cand_col_d = piece_col_q + 6'd1;
                    state_d    = S_CHECK;
                end else if (cmd_drop || fall_pend_q) begin
                    cand_row_d = piece_row_q + 6'd1;
                    kind_d     = K_DOWN;
                    down_go    = 1'b1;
                    state_d    = S_CHECK;
                end
            end
            S_CHECK: begin
                state_d = oob ? hit_state : S_WAIT;
            end
            S_WAIT: begin
                if (chk_ack) begin
                    if (chk_hit) begin
                        state_d = hit_state;
                    end else begin
                        commit  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_LOCK: begin
                if (lock_ready) begin
                    piece_mask_d = 12'h000;
                    state_d      = S_SPAWN;
                end
            end
            default: begin
                state_d = S_OVER;
            end
        endcase

        if (commit) begin
            piece_rot_d  = cand_rot_q;
            piece_col_d  = cand_col_q;
            piece_row_d  = cand_row_q;
            piece_mask_d = cand_mask;
        end

        // Gravity only advances while a piece is live and not locking.
        if (state_q == S_IDLE || state_q == S_CHECK || state_q == S_WAIT) begin
            if (cnt_q == CNT_W'(FALL_TICKS - 1)) begin
                cnt_d       = '0;
                fall_pend_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        // A dispatched down move absorbs a gravity step landing in the same cycle.
        if (down_go)
            fall_pend_d = 1'b0;
        if (commit && kind_q == K_SPAWN)
            cnt_d = '0;

        chk_req_d    = (state_d == S_WAIT);
        lock_valid_d = (state_d == S_LOCK);
        game_over_d  = game_over_q || (state_d == S_OVER);
        ref_x_d      = 10'(ORIGIN_X) + {{4{piece_col_d[5]}}, piece_col_d} * 10'(SIZE);
        ref_y_d      = 10'(ORIGIN_Y) + {{4{piece_row_d[5]}}, piece_row_d} * 10'(SIZE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_SPAWN;
            kind_q       <= K_SPAWN;
            piece_type_q <= 3'd0;
            piece_rot_q  <= 2'd0;
            piece_col_q  <= 6'(SPAWN_COL);
            piece_row_q  <= 6'd0;
            piece_mask_q <= 12'h000;
            cand_rot_q   <= 2'd0;
            cand_col_q   <= 6'(SPAWN_COL);
            cand_row_q   <= 6'd0;
            cnt_q        <= '0;
            fall_pend_q  <= 1'b0;
            chk_req_q    <= 1'b0;
            lock_valid_q <= 1'b0;
            next_take_q  <= 1'b0;
            game_over_q  <= 1'b0;
            ref_x_q      <= 10'(ORIGIN_X) + 10'(SPAWN_COL) * 10'(SIZE);
            ref_y_q      <= 10'(ORIGIN_Y);
        end else begin
            state_q      <= state_d;
            kind_q       <= kind_d;
            piece_type_q <= piece_type_d;
            piece_rot_q  <= piece_rot_d;
            piece_col_q  <= piece_col_d;
            piece_row_q  <= piece_row_d;
            piece_mask_q <= piece_mask_d;
            cand_rot_q   <= cand_rot_d;
            cand_col_q   <= cand_col_d;
            cand_row_q   <= cand_row_d;
            cnt_q        <= cnt_d;
            fall_pend_q  <= fall_pend_d;
            chk_req_q    <= chk_req_d;
            lock_valid_q <= lock_valid_d;
            next_take_q  <= next_take_d;
            game_over_q  <= game_over_d;
            ref_x_q      <= ref_x_d;
            ref_y_q      <= ref_y_d;
        end
    end

endmodule

// File: tb/tb_piece_ctrl.sv
// Directed bench for piece_ctrl: spawn, walls, rotation, priority,
// gravity lock with lock handshake, game over and reset mid-query.
module tb_piece_ctrl;

  localparam int FT = 300;
  localparam int ST_SPAWN = 0;
  localparam int ST_IDLE  = 1;
  localparam int ST_CHECK = 2;
  localparam int ST_WAIT  = 3;
  localparam int ST_LOCK  = 4;
  localparam int ST_OVER  = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  next_piece = 3'd0;
  logic        next_take;
  logic        cmd_left = 1'b0, cmd_right = 1'b0, cmd_rot = 1'b0, cmd_drop = 1'b0;
  logic        chk_req;
  logic [5:0]  cand_col, cand_row;
  logic [11:0] cand_mask;
  logic        chk_ack = 1'b0, chk_hit = 1'b0;
  logic        lock_valid;
  logic        lock_ready = 1'b0;
  logic [5:0]  piece_col, piece_row;
  logic [11:0] piece_mask;
  logic [9:0]  ref_x, ref_y;
  logic        game_over;
  logic [2:0]  dbg_state;

  int tests_run = 0;
  int tests_failed = 0;

  piece_ctrl #(
    .COLS(10), .ROWS(20), .SIZE(16), .ORIGIN_X(160), .ORIGIN_Y(80),
    .FALL_TICKS(FT), .SPAWN_COL(4)
  ) dut (
    .clk(clk), .rst(rst), .next_piece(next_piece), .next_take(next_take),
    .cmd_left(cmd_left), .cmd_right(cmd_right), .cmd_rot(cmd_rot), .cmd_drop(cmd_drop),
    .chk_req(chk_req), .cand_col(cand_col), .cand_row(cand_row), .cand_mask(cand_mask),
    .chk_ack(chk_ack), .chk_hit(chk_hit), .lock_valid(lock_valid), .lock_ready(lock_ready),
    .piece_col(piece_col), .piece_row(piece_row), .piece_mask(piece_mask),
    .ref_x(ref_x), .ref_y(ref_y), .game_over(game_over), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // From a sample point in SPAWN: take, query, answer.
  task automatic spawn(input logic [2:0] p, input logic hit, input logic [31:0] exp_mask,
                       input string tag);
    next_piece = p;
    tick();
    check({tag, "_take"}, 32'(next_take), 1);
    check({tag, "_req_early"}, 32'(chk_req), 0);
    tick();
    check({tag, "_req"}, 32'(chk_req), 1);
    check({tag, "_cmask"}, 32'(cand_mask), exp_mask);
    check({tag, "_ccol"}, 32'(cand_col), 4);
    chk_ack = 1'b1;
    chk_hit = hit;
    tick();
    chk_ack = 1'b0;
    chk_hit = 1'b0;
    check({tag, "_req_drop"}, 32'(chk_req), 0);
  endtask

  // One command pulse from IDLE: 0 rot, 1 left, 2 right, 3 drop.
  task automatic move(input int which, input logic hit, input logic exp_req, input string tag);
    case (which)
      0: cmd_rot = 1'b1;
      1: cmd_left = 1'b1;
      2: cmd_right = 1'b1;
      default: cmd_drop = 1'b1;
    endcase
    tick();
    cmd_rot = 1'b0; cmd_left = 1'b0; cmd_right = 1'b0; cmd_drop = 1'b0;
    check({tag, "_state_chk"}, 32'(dbg_state), ST_CHECK);
    tick();
    check({tag, "_req"}, 32'(chk_req), 32'(exp_req));
    if (chk_req) begin
      chk_ack = 1'b1;
      chk_hit = hit;
      tick();
      chk_ack = 1'b0;
      chk_hit = 1'b0;
      check({tag, "_req_drop"}, 32'(chk_req), 0);
    end
  endtask

  initial begin
    bit found;
    bit seen_req;

    // reset values, sampled while reset is still held
    next_piece = 3'd2;
    rst = 1'b1;
    tick();
    check("rst_state", 32'(dbg_state), ST_SPAWN);
    check("rst_mask", 32'(piece_mask), 0);
    check("rst_col", 32'(piece_col), 4);
    check("rst_row", 32'(piece_row), 0);
    check("rst_refx", 32'(ref_x), 224);
    check("rst_refy", 32'(ref_y), 80);
    check("rst_req", 32'(chk_req), 0);
    check("rst_lock", 32'(lock_valid), 0);
    check("rst_take", 32'(next_take), 0);
    check("rst_over", 32'(game_over), 0);
    rst = 1'b0;

    // spawn T, then walk it to the left wall
    spawn(3'd2, 1'b0, 'h0E2, "spawn_t");
    check("spawn_mask", 32'(piece_mask), 'h0E2);
    check("spawn_refx", 32'(ref_x), 224);
    check("spawn_refy", 32'(ref_y), 80);
    check("spawn_take_end", 32'(next_take), 0);
    check("spawn_idle", 32'(dbg_state), ST_IDLE);
    move(1, 1'b0, 1'b1, "left1");
    check("left1_col", 32'(piece_col), 3);
    check("left1_refx", 32'(ref_x), 208);
    move(1, 1'b0, 1'b1, "left2");
    check("left2_col", 32'(piece_col), 2);
    move(1, 1'b0, 1'b1, "left3");
    check("left3_col", 32'(piece_col), 1);
    check("left3_refx", 32'(ref_x), 176);
    move(1, 1'b0, 1'b0, "left_oob");
    check("left_oob_col", 32'(piece_col), 1);
    check("left_oob_refx", 32'(ref_x), 176);
    check("left_oob_state", 32'(dbg_state), ST_IDLE);
    move(2, 1'b0, 1'b1, "right");
    check("right_col", 32'(piece_col), 2);
    check("right_refx", 32'(ref_x), 192);

    // rotation blocked then allowed; type 7 behaves as I
    do_reset();
    spawn(3'd7, 1'b0, 'h00F, "spawn_i");
    move(0, 1'b1, 1'b1, "rot_hit");
    check("rot_hit_mask", 32'(piece_mask), 'h00F);
    move(0, 1'b0, 1'b1, "rot_ok");
    check("rot_ok_mask", 32'(piece_mask), 'hA42);

    // rot and left together: only the rotation is queried
    cmd_rot = 1'b1;
    cmd_left = 1'b1;
    tick();
    cmd_rot = 1'b0;
    cmd_left = 1'b0;
    tick();
    check("prio_req", 32'(chk_req), 1);
    check("prio_ccol", 32'(cand_col), 4);
    check("prio_cmask", 32'(cand_mask), 'h00F);
    chk_ack = 1'b1;
    tick();
    chk_ack = 1'b0;
    check("prio_mask", 32'(piece_mask), 'h00F);
    check("prio_col", 32'(piece_col), 4);

    // floor lock: drop O to row 18, gravity pushes it out of bounds
    do_reset();
    spawn(3'd1, 1'b0, 'h0C6, "spawn_o");
    for (int i = 0; i < 18; i++) move(3, 1'b0, 1'b1, "drop");
    check("drop_row", 32'(piece_row), 18);
    check("drop_refy", 32'(ref_y), 368);
    found = 1'b0;
    seen_req = 1'b0;
    for (int i = 0; i < 2 * FT && !found; i++) begin
      tick();
      if (chk_req) seen_req = 1'b1;
      if (lock_valid) found = 1'b1;
    end
    check("grav_lock", 32'(found), 1);
    check("grav_noreq", 32'(seen_req), 0);
    check("lock_row", 32'(piece_row), 18);
    check("lock_mask", 32'(piece_mask), 'h0C6);
    for (int i = 0; i < 5; i++) tick();
    check("lock_hold_valid", 32'(lock_valid), 1);
    check("lock_hold_row", 32'(piece_row), 18);
    check("lock_hold_state", 32'(dbg_state), ST_LOCK);
    next_piece = 3'd5;
    lock_ready = 1'b1;
    tick();
    lock_ready = 1'b0;
    check("lock_drop", 32'(lock_valid), 0);
    check("lock_clear", 32'(piece_mask), 0);
    check("lock_spawn", 32'(dbg_state), ST_SPAWN);
    spawn(3'd5, 1'b0, 'h0E1, "respawn");
    check("respawn_mask", 32'(piece_mask), 'h0E1);
    check("respawn_row", 32'(piece_row), 0);
    check("respawn_refy", 32'(ref_y), 80);

    // game over on spawn hit; commands ignored afterwards
    do_reset();
    spawn(3'd3, 1'b1, 'h066, "spawn_s");
    check("over_flag", 32'(game_over), 1);
    check("over_state", 32'(dbg_state), ST_OVER);
    check("over_mask", 32'(piece_mask), 0);
    cmd_drop = 1'b1;
    cmd_left = 1'b1;
    tick();
    cmd_drop = 1'b0;
    cmd_left = 1'b0;
    seen_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (chk_req) seen_req = 1'b1;
    end
    check("over_noreq", 32'(seen_req), 0);
    check("over_sticky", 32'(game_over), 1);
    do_reset();
    check("over_cleared", 32'(game_over), 0);

    // reset during WAIT drops chk_req; a late ack is ignored
    next_piece = 3'd4;
    tick();
    tick();
    check("midrst_req", 32'(chk_req), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_req_drop", 32'(chk_req), 0);
    chk_ack = 1'b1;
    tick();
    chk_ack = 1'b0;
    check("late_ack_mask", 32'(piece_mask), 0);
    check("late_ack_state", 32'(dbg_state), ST_CHECK);
    tick();
    check("late_ack_req", 32'(chk_req), 1);
    check("late_ack_cmask", 32'(cand_mask), 'h0C3);
    chk_ack = 1'b1;
    tick();
    chk_ack = 1'b0;
    check("z_mask", 32'(piece_mask), 'h0C3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
